// File: rtl/leaf_arb_pkg.sv
// rtl/leaf_arb_pkg.sv - shared state encoding and sizing helper for leaf_stream_arbiter
//
// Contents:
//   ST_IDLE / ST_GRANT : arbiter FSM state encoding
//   clog2()            : ceiling log2, used for counter/index sizing and tag-width checks
package leaf_arb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Number of bits needed to encode values 0..value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/leaf_stream_arbiter_rr_pick.sv
// rtl/leaf_stream_arbiter_rr_pick.sv - combinational round-robin priority selector
//
// Ports:
//   req  in  NUM_REQ  request bits
//   last in  IDX_W    index served most recently; search starts at last+1
//   any  out 1        at least one request bit is set
//   idx  out IDX_W    first requester found cyclically after last
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    int               pos;
    logic [IDX_W-1:0] pos_idx;

    // Walk from the farthest candidate back to the nearest one, so the
    // requester closest after last is the final (winning) assignment.
    always_comb begin
        any     = 1'b0;
        idx     = '0;
        pos     = 0;
        pos_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            pos = int'(last) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            pos_idx = IDX_W'(pos);
            if (req[pos_idx]) begin
                any = 1'b1;
                idx = pos_idx;
            end
        end
    end

endmodule

// File: rtl/leaf_stream_arbiter.sv
// rtl/leaf_stream_arbiter.sv - round-robin burst arbiter feeding one leaf interface input port
//
// Ports:
//   clk       in  1                     single clock
//   reset     in  1                     synchronous, active-low reset
//   ap_start  in  1                     enables new grants (never aborts a running burst)
//   req_din   in  NUM_REQ*PAYLOAD_BITS  stream i word at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//   req_vld   in  NUM_REQ               per-stream valid
//   req_ack   out NUM_REQ               per-stream acknowledge (combinational, one-hot or zero)
//   dout      out PAYLOAD_BITS          registered output word
//   dout_vld  out 1                     output word valid
//   dout_ack  in  1                     downstream acknowledge
//   dout_src  out SRC_BITS              index of the stream that produced dout
//   busy      out 1                     high while granting or while dout_vld is high
module leaf_stream_arbiter
    import leaf_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = 32,
    parameter int BURST_LEN    = 16,
    parameter int SRC_BITS     = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ap_start,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_din,
    input  logic [NUM_REQ-1:0]              req_vld,
    output logic [NUM_REQ-1:0]              req_ack,
    output logic [PAYLOAD_BITS-1:0]         dout,
    output logic                            dout_vld,
    input  logic                            dout_ack,
    output logic [SRC_BITS-1:0]             dout_src,
    output logic                            busy
);

    localparam int IDX_W = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);
    localparam int CNT_W = (clog2(BURST_LEN) < 1) ? 1 : clog2(BURST_LEN);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (NUM_REQ < 2 || clog2(NUM_REQ) > SRC_BITS) begin : g_bad_cfg
        $error("leaf_stream_arbiter: NUM_REQ must be >= 2 and fit in SRC_BITS");
    end

    logic [0:0]              state;
    logic [IDX_W-1:0]        g;
    logic [IDX_W-1:0]        last;
    logic [CNT_W-1:0]        cnt;
    logic                    pick_any;
    logic [IDX_W-1:0]        pick_idx;
    logic                    g_vld;
    logic [PAYLOAD_BITS-1:0] g_word;
    logic                    out_free;
    logic                    accept;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req  (req_vld),
        .last (last),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // Constant-index mux of the granted stream's valid and word.
    always_comb begin
        g_vld  = 1'b0;
        g_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (g == IDX_W'(i)) begin
                g_vld  = req_vld[i];
                g_word = req_din[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    // The output register can take a new word when empty or being drained.
    assign out_free = !dout_vld || dout_ack;
    assign accept   = (state == ST_GRANT) && g_vld && out_free;
    assign busy     = (state == ST_GRANT) || dout_vld;

    always_comb begin
        req_ack = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ack[i] = accept && (g == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            g        <= '0;
            last     <= IDX_LAST;
            cnt      <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
            dout_src <= '0;
        end else begin
            // Output register drains independently of the FSM and ap_start.
            if (accept) begin
                dout     <= g_word;
                dout_src <= SRC_BITS'(g);
                dout_vld <= 1'b1;
            end else if (out_free) begin
                dout_vld <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (ap_start && pick_any) begin
                        g     <= pick_idx;
                        cnt   <= '0;
                        state <= ST_GRANT;
                    end
                end
                default: begin
                    if (accept) begin
                        cnt <= cnt + CNT_ONE;
                    end
                    // Burst ends on its last word or as soon as the owner goes idle.
                    if ((accept && cnt == CNT_LAST) || !g_vld) begin
                        state <= ST_IDLE;
                        last  <= g;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end

endmodule
